// File: rtl/fir_decim_fifo_pkg.sv
// Shared constants and types for the FIR filter stage and its downstream consumers.
// Pure declarations; no timing and no flow control of its own.
package fir_pkg;

  localparam int DATA_W      = 16;
  localparam int TAPS        = 32;
  localparam int FIR_LATENCY = 4;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Warm-up discards aligned samples until the filter's delay line is full.
  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } dstate_t;

endpackage

// File: rtl/fir_decim_fifo_sync_fifo.sv
// Show-ahead FIFO with a registered head: dout shows the head one cycle after a push to empty.
// A push while full succeeds only alongside a pop; otherwise the caller drops it. dout holds when empty.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     full,
  output logic                     empty,
  output logic [AW:0]              fill
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      // The incoming sample becomes head only when nothing older survives this edge.
      if (push_ok && (empty || (fill == (AW+1)'(1) && pop_ok))) begin
        dout <= din;
      end else if (pop_ok && fill > (AW+1)'(1)) begin
        dout <= mem[rd_ptr + 1'b1];
      end
    end
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Aligns the filter strobe by LATENCY, drops WARMUP samples, keeps 1 of DECIM into a FIFO.
// A kept sample is visible on m_data one cycle later; when full without a pop it is dropped and overflow sticks.
module fir_decim_fifo #(
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int LATENCY = fir_pkg::FIR_LATENCY,
  parameter int WARMUP  = fir_pkg::TAPS,
  parameter int DECIM   = 4,
  parameter int DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic signed [DATA_W-1:0]   filt_data,
  input  logic                       clr,
  output logic signed [DATA_W-1:0]   m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow
);
  import fir_pkg::*;

  localparam int WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [LATENCY-1:0] al_pipe;
  logic               strb_al;
  dstate_t            state, state_nxt;
  logic [WC_W-1:0]    warm_cnt, warm_nxt;
  logic [PH_W-1:0]    phase, phase_nxt;
  logic               push_req;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  assign strb_al = al_pipe[LATENCY-1];
  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_pipe  <= '0;
      state    <= ST_WARM;
      warm_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      al_pipe  <= '0;
      state    <= ST_WARM;
      warm_cnt <= '0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      al_pipe  <= (al_pipe << 1) | LATENCY'(enable);
      state    <= state_nxt;
      warm_cnt <= warm_nxt;
      phase    <= phase_nxt;
      overflow <= overflow | (push_req & fifo_full & ~pop);
    end
  end

  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    phase_nxt = phase;
    push_req  = 1'b0;
    case (state)
      ST_WARM: begin
        if (strb_al) begin
          warm_nxt = warm_cnt + 1'b1;
          if (warm_nxt == WC_W'(WARMUP)) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Phase 0 is kept so the first sample after warm-up is always emitted.
        if (strb_al) begin
          push_req  = (phase == '0);
          phase_nxt = (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
        end
      end
      default: state_nxt = ST_WARM;
    endcase
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push_req),
    .pop   (pop),
    .din   (filt_data),
    .dout  (m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: a DECIM=4 and a DECIM=1 instance share one delayed-index filter model.
// Expected samples are queued per instance on each modelled keep and compared when the DUT pops them.
module tb_fir_decim_fifo;

  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               clr;
  logic signed [15:0] filt_data;
  logic signed [15:0] md [2];
  logic               mv [2];
  logic               mr [2];
  logic [3:0]         fl [2];
  logic               ov [2];

  fir_decim_fifo #(.DATA_W(16), .LATENCY(4), .WARMUP(32), .DECIM(4), .DEPTH(8)) u_d4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .filt_data(filt_data), .clr(clr),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .fill(fl[0]), .overflow(ov[0])
  );

  fir_decim_fifo #(.DATA_W(16), .LATENCY(4), .WARMUP(32), .DECIM(1), .DEPTH(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .filt_data(filt_data), .clr(clr),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .fill(fl[1]), .overflow(ov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errs;
  int   checks;
  int   wc [2];
  int   ph [2];
  int   dec [2];
  bit   ovm [2];
  int   q0 [$];
  int   q1 [$];
  int   got0 [$];
  int   got1 [$];
  logic [3:0] pe;
  int   pd [4];
  int   idx;
  int   maxfill0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int k, input int v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic mclear(input int k);
    wc[k]  = 0;
    ph[k]  = 0;
    ovm[k] = 1'b0;
    if (k == 0) q0.delete();
    else        q1.delete();
  endtask

  task automatic mreset_all();
    mclear(0);
    mclear(1);
    pe  = '0;
    idx = 0;
    for (int i = 0; i < 4; i++) pd[i] = 0;
    filt_data = '0;
  endtask

  // One clock: model the edge with the current inputs, then check the DUTs after it.
  task automatic cyc();
    int sz;
    bit pop;
    bit keep;
    bit strb;
    strb = pe[3];
    for (int k = 0; k < 2; k++) begin
      sz = qsize(k);
      if (clr) begin
        mclear(k);
      end else begin
        pop = mr[k] && (sz > 0);
        if (pop) begin
          chk($sformatf("m_data%0d", k), 32'(md[k]), 32'(qfront(k)));
          if (k == 0) got0.push_back(int'(md[0]));
          else        got1.push_back(int'(md[1]));
          qpop(k);
        end
        keep = strb && (wc[k] == W) && (ph[k] == 0);
        if (strb) begin
          if (wc[k] < W) wc[k]++;
          else           ph[k] = (ph[k] + 1) % dec[k];
        end
        if (keep) begin
          if (sz < DEPTH || pop) qpush(k, int'(filt_data));
          else                   ovm[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    pe = clr ? 4'b0 : {pe[2:0], enable};
    pd[3] = pd[2];
    pd[2] = pd[1];
    pd[1] = pd[0];
    pd[0] = enable ? idx : 0;
    if (enable) idx++;
    filt_data = 16'(pd[3]);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_valid%0d", k), 32'(mv[k]), 32'(qsize(k) != 0));
      chk($sformatf("fill%0d", k), 32'(fl[k]), 32'(qsize(k)));
      chk($sformatf("overflow%0d", k), 32'(ov[k]), 32'(ovm[k]));
    end
    if (int'(fl[0]) > maxfill0) maxfill0 = int'(fl[0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int rec;
    bit done;
    bit keepnow;
    errs     = 0;
    checks   = 0;
    dec[0]   = 4;
    dec[1]   = 1;
    maxfill0 = 0;
    rst_n    = 1'b0;
    enable   = 1'b0;
    clr      = 1'b0;
    mr[0]    = 1'b0;
    mr[1]    = 1'b0;
    rec      = 0;
    mreset_all();

    // Reset state
    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(mv[k]), 32'd0);
      chk($sformatf("rst_fill%0d", k), 32'(fl[k]), 32'd0);
      chk($sformatf("rst_ovf%0d", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_data%0d", k), 32'(md[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Warm-up with back-to-back strobes, then decimation at one strobe every 3 cycles
    mr[0] = 1'b1;
    mr[1] = 1'b1;
    enable = 1'b1;
    repeat (36) cyc();
    chk("warmup_hold", 32'(mv[0]), 32'd0);
    enable = 1'b0;
    cyc();
    chk("first_valid", 32'(mv[0]), 32'd1);
    chk("first_data", 32'(md[0]), 32'd32);
    for (int i = 0; i < 48; i++) begin
      enable = (i % 3 == 0);
      cyc();
    end
    enable = 1'b0;
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) chk($sformatf("decim_seq%0d", i), 32'(got0[i]), 32'(32 + 4 * i));
    chk("decim_maxfill", 32'(maxfill0), 32'd1);
    chk("decim_ovf", 32'(ov[0]), 32'd0);

    // Async reset mid-run with five entries buffered
    mr[0] = 1'b0;
    mr[1] = 1'b0;
    enable = 1'b1;
    n = 0;
    while (qsize(0) != 5 && n < 200) begin
      cyc();
      n++;
    end
    chk("fill5_reached", 32'(fl[0]), 32'd5);
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("arst_valid%0d", k), 32'(mv[k]), 32'd0);
      chk($sformatf("arst_fill%0d", k), 32'(fl[k]), 32'd0);
      chk($sformatf("arst_ovf%0d", k), 32'(ov[k]), 32'd0);
    end
    mreset_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh warm-up, fill to DEPTH, then drop the ninth kept sample (64)
    got0.delete();
    enable = 1'b1;
    repeat (36) cyc();
    chk("rewarm_hold", 32'(mv[0]), 32'd0);
    repeat (29) cyc();
    chk("full_fill", 32'(fl[0]), 32'd8);
    chk("full_valid", 32'(mv[0]), 32'd1);
    chk("full_ovf", 32'(ov[0]), 32'd0);
    enable = 1'b0;
    repeat (4) cyc();
    chk("drop_fill", 32'(fl[0]), 32'd8);
    chk("drop_ovf", 32'(ov[0]), 32'd1);
    mr[0] = 1'b1;
    mr[1] = 1'b1;
    repeat (12) cyc();
    chk("drain_count", 32'(got0.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("drain%0d", i), 32'(got0[i]), 32'(32 + 4 * i));

    // clr with three entries in the DECIM=1 instance
    mr[1] = 1'b0;
    enable = 1'b1;
    repeat (3) cyc();
    enable = 1'b0;
    repeat (5) cyc();
    chk("preclr_fill1", 32'(fl[1]), 32'd3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_fill1", 32'(fl[1]), 32'd0);
    chk("clr_valid1", 32'(mv[1]), 32'd0);
    chk("clr_ovf0", 32'(ov[0]), 32'd0);
    got1.delete();
    base  = idx;
    mr[1] = 1'b1;
    mr[0] = 1'b0;
    enable = 1'b1;
    repeat (40) cyc();
    enable = 1'b0;
    repeat (6) cyc();
    chk("clr_out_count", 32'(got1.size()), 32'd8);
    chk("clr_first", 32'(got1[0]), 32'(base + 32));
    chk("clr_last", 32'(got1[7]), 32'(base + 39));

    // Push request and pop in the same cycle while full
    enable = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      keepnow = pe[3] && (wc[0] == W) && (ph[0] == 0);
      if (qsize(0) == DEPTH && keepnow) begin
        mr[0]  = 1'b1;
        enable = 1'b0;
        rec    = int'(filt_data);
        cyc();
        mr[0] = 1'b0;
        done  = 1'b1;
        chk("simul_fill", 32'(fl[0]), 32'd8);
        chk("simul_ovf", 32'(ov[0]), 32'd0);
      end else begin
        cyc();
      end
      n++;
    end
    chk("simul_reached", 32'(done), 32'd1);
    enable = 1'b0;
    repeat (5) cyc();
    got0.delete();
    mr[0] = 1'b1;
    repeat (12) cyc();
    chk("simul_drain_count", 32'(got0.size()), 32'd8);
    if (got0.size() > 0) chk("simul_last", 32'(got0[got0.size() - 1]), 32'(rec));
    chk("simul_ovf_end", 32'(ov[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream consumer of the 32-tap FIR filter stage.
- Aligns the filter's sample strobe with the filter's fixed pipeline latency, then discards warm-up samples.
- Decimates the filtered stream by DECIM and buffers the results in a small FIFO.
- Presents the buffered samples on a valid/ready stream to the next stage (DMA or DAC formatter).

Parameters:
- DATA_W, 16, width of filtered samples and output data.
- LATENCY, 4, clock cycles from an enable-qualified clock edge at the filter to the matching result on filt_data.
- WARMUP, 32, number of aligned samples discarded after reset or clr; equals the filter tap count.
- DECIM, 4, decimation ratio, >= 1; DECIM = 1 means no decimation.
- DEPTH, 8, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; same clock as the filter.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  sample strobe; the same signal that drives the filter enable.
- filt_data  in  DATA_W  signed filter output (outData).
- clr  in  1  synchronous soft clear; same effect as reset except on clk.
- m_data  out  DATA_W  signed head-of-FIFO sample.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream accept.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag; a decimated sample was dropped.

Behaviour:
- Reset (rst_n low, async) or clr (sync): all outputs and internal state go to 0.
  - Covers m_valid, m_data, fill, overflow, the alignment pipe, the warm-up counter, the decimation phase and the FIFO pointers.
  - Reset or clr asserted mid-operation discards FIFO contents immediately.
- Alignment: enable feeds a LATENCY-deep shift register, advancing every clk.
  - Its output is strb_al.
  - strb_al high means filt_data in that cycle is the result for that strobe.
  - Back-to-back enable strobes (every cycle) must be supported.
- Warm-up: a counter counts strb_al up to WARMUP and then saturates.
  - While the counter is below WARMUP, strb_al samples are discarded and do not advance the decimation phase.
  - Once the counter reaches WARMUP, the state is "run".
- Decimation: phase counter runs 0..DECIM-1 and advances on each run-state strb_al, wrapping to 0.
  - A sample is kept (push request) when phase == 0, so the first post-warm-up sample is kept.
- FIFO:
  - Show-ahead, registered storage.
  - m_data always equals the head entry while m_valid = 1; m_data holds its last value when empty.
  - pop = m_valid & m_ready.
  - push accepted if not full, or if full and pop in the same cycle.
  - Push and pop in the same cycle: fill unchanged; ordering preserved.
  - Push request while full without pop: the sample is dropped, overflow sets, fill stays DEPTH.
  - Pointers wrap modulo DEPTH.
  - fill updates in the same cycle as the push or pop edge.
- Latency, empty FIFO: the keep-sample at strb_al in cycle t gives m_valid = 1 and m_data = sample in cycle t+1.
- overflow clears only on reset or clr.
- Data is passed unmodified; no rounding or saturation in this block.

Decomposition:
- Shared package fir_pkg holds:
  - DATA_W and TAPS = 32 constants;
  - the sample_t typedef (logic signed [DATA_W-1:0]);
  - FIR_LATENCY = 4.
- One sub-module: sync_fifo.
  - Parameters: DATA_W, DEPTH.
  - Ports: push, pop, din, dout, full, empty, fill.
- The top instantiates sync_fifo and holds the alignment pipe, warm-up counter and decimation phase logic.

Test Plan:
- Warm-up: reset, then enable every cycle with filt_data = strobe index (0,1,2...) delayed by 4. The first 32 aligned samples are discarded; m_valid first rises 1 cycle after the aligned strobe of index 32. m_data = 32.
- Decimation, DECIM = 4, m_ready = 1, enable every 3rd cycle: after warm-up the output sequence is 32, 36, 40, 44; fill never exceeds 1; overflow = 0.
- Overflow, DEPTH = 8, m_ready = 0: after 8 kept samples fill = 8 and m_valid = 1. The 9th kept sample (value 64) is dropped and overflow = 1. Raising m_ready then drains exactly 32..60 in steps of 4.
- Simultaneous push and pop at full: fill = 8, m_ready = 1 in the cycle of a push request. fill stays 8, no overflow, and the new sample appears last in the drain order.
- Reset mid-run: assert rst_n low asynchronously between clock edges with fill = 5. m_valid, fill and overflow drop to 0 without a clock edge. After release, a full 32-sample warm-up is required again.
- clr with DECIM = 1: clr pulsed for one cycle with fill = 3. The next cycle shows fill = 0, m_valid = 0, warm-up restarted; after warm-up every aligned sample is output.
